// File: rtl/counter_pkg.sv
// Shared types for the stopwatch lap recorder: display FSM states and the
// 24-bit lap timestamp {min, sec, ms_10}.
package counter_pkg;

    localparam int FIELD_W = 8;
    localparam int TIME_W  = 3 * FIELD_W;

    typedef enum logic {
        LIVE = 1'b0,
        VIEW = 1'b1
    } lap_state_e;

    typedef struct packed {
        logic [FIELD_W-1:0] min;
        logic [FIELD_W-1:0] sec;
        logic [FIELD_W-1:0] ms_10;
    } lap_time_t;

endpackage

// File: rtl/lap_recorder_if.sv
// Control strobes, live time in, displayed time and lap status out.
interface lap_recorder_if #(
    parameter int DEPTH = 4
);
    localparam int IDX_W = $clog2(DEPTH);

    logic             run_en;
    logic             clear;
    logic             rec_pulse;
    logic             view_pulse;
    logic [7:0]       min_i;
    logic [7:0]       sec_i;
    logic [7:0]       ms_10_i;
    logic [7:0]       min_o;
    logic [7:0]       sec_o;
    logic [7:0]       ms_10_o;
    logic [IDX_W-1:0] lap_idx;
    logic [IDX_W:0]   lap_cnt;
    logic             viewing;
    logic             full;
    logic             overflow;

    modport master (
        output run_en, clear, rec_pulse, view_pulse, min_i, sec_i, ms_10_i,
        input  min_o, sec_o, ms_10_o, lap_idx, lap_cnt, viewing, full, overflow
    );

    modport slave (
        input  run_en, clear, rec_pulse, view_pulse, min_i, sec_i, ms_10_i,
        output min_o, sec_o, ms_10_o, lap_idx, lap_cnt, viewing, full, overflow
    );

endinterface

// File: rtl/lap_store.sv
// DEPTH x 24-bit lap register file: one synchronous write port, one
// combinational read port. Contents are not reset.
module lap_store
    import counter_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  lap_time_t        i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output lap_time_t        o_rdata
);

    lap_time_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lap_recorder.sv
// Stopwatch lap recorder: captures up to DEPTH lap times and lets the user
// step through them; all outputs registered with one cycle of latency.
module lap_recorder
    import counter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk_core,
    input  logic          rst,
    lap_recorder_if.slave bus
);

    localparam int              IDX_W   = $clog2(DEPTH);
    localparam int              CNT_W   = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    lap_state_e       r_state;
    lap_state_e       w_state_nxt;
    logic [IDX_W-1:0] r_lap_idx;
    logic [IDX_W-1:0] w_lap_idx_nxt;
    logic [CNT_W-1:0] r_lap_cnt;
    logic [CNT_W-1:0] w_lap_cnt_nxt;
    logic             r_overflow;
    logic             w_overflow_nxt;
    logic             r_viewing;
    logic             r_full;
    lap_time_t        r_disp;
    lap_time_t        w_disp_nxt;
    lap_time_t        w_live;
    lap_time_t        w_rd;
    logic             w_rec_ok;
    logic             w_rec_drop;
    logic             w_cnt_nz;
    logic             w_view_last;

    assign w_live      = {bus.min_i, bus.sec_i, bus.ms_10_i};
    assign w_rec_ok    = bus.rec_pulse & bus.run_en & (r_lap_cnt != CNT_MAX);
    assign w_rec_drop  = bus.rec_pulse & bus.run_en & (r_lap_cnt == CNT_MAX);
    assign w_cnt_nz    = (r_lap_cnt != '0);
    // View decisions always use the count from before this cycle's capture.
    assign w_view_last = ({1'b0, r_lap_idx} == (r_lap_cnt - CNT_W'(1)));

    lap_store #(
        .DEPTH (DEPTH)
    ) u_store (
        .clk     (clk_core),
        .i_we    (w_rec_ok & ~bus.clear),
        .i_waddr (r_lap_cnt[IDX_W-1:0]),
        .i_wdata (w_live),
        .i_raddr (w_lap_idx_nxt),
        .o_rdata (w_rd)
    );

    always_ff @(posedge clk_core or negedge rst) begin
        if (!rst) begin
            r_state <= LIVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.clear) begin
            w_state_nxt = LIVE;
        end else begin
            case (r_state)
                LIVE:    if (bus.view_pulse && w_cnt_nz)    w_state_nxt = VIEW;
                VIEW:    if (bus.view_pulse && w_view_last) w_state_nxt = LIVE;
                default: w_state_nxt = LIVE;
            endcase
        end
    end

    always_comb begin
        w_lap_cnt_nxt  = r_lap_cnt;
        w_lap_idx_nxt  = r_lap_idx;
        w_overflow_nxt = r_overflow;
        if (bus.clear) begin
            w_lap_cnt_nxt  = '0;
            w_lap_idx_nxt  = '0;
            w_overflow_nxt = 1'b0;
        end else begin
            if (w_rec_ok)   w_lap_cnt_nxt  = r_lap_cnt + CNT_W'(1);
            if (w_rec_drop) w_overflow_nxt = 1'b1;
            if (bus.view_pulse) begin
                if (r_state == LIVE || w_view_last) w_lap_idx_nxt = '0;
                else                                w_lap_idx_nxt = r_lap_idx + IDX_W'(1);
            end
        end
        w_disp_nxt = (w_state_nxt == VIEW) ? w_rd : w_live;
    end

    always_ff @(posedge clk_core or negedge rst) begin
        if (!rst) begin
            r_lap_cnt  <= '0;
            r_lap_idx  <= '0;
            r_overflow <= 1'b0;
            r_viewing  <= 1'b0;
            r_full     <= 1'b0;
            r_disp     <= '0;
        end else begin
            r_lap_cnt  <= w_lap_cnt_nxt;
            r_lap_idx  <= w_lap_idx_nxt;
            r_overflow <= w_overflow_nxt;
            r_viewing  <= (w_state_nxt == VIEW);
            r_full     <= (w_lap_cnt_nxt == CNT_MAX);
            r_disp     <= w_disp_nxt;
        end
    end

    assign bus.min_o    = r_disp.min;
    assign bus.sec_o    = r_disp.sec;
    assign bus.ms_10_o  = r_disp.ms_10;
    assign bus.lap_idx  = r_lap_idx;
    assign bus.lap_cnt  = r_lap_cnt;
    assign bus.viewing  = r_viewing;
    assign bus.full     = r_full;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_lap_recorder.sv
// Directed bench for lap_recorder (DEPTH=4): vector table plus reset sequences.
module tb_lap_recorder;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    lap_recorder_if #(.DEPTH(4)) bus ();

    lap_recorder #(.DEPTH(4)) dut (
        .clk_core (clk),
        .rst      (rst),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        run;
        logic        clr;
        logic        rec;
        logic        view;
        logic [23:0] tin;
        logic [23:0] tout;
        int          idx;
        int          cnt;
        logic        vw;
        logic        fl;
        logic        ov;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic run, logic clr, logic rec, logic view,
                                logic [23:0] tin, logic [23:0] tout,
                                int idx, int cnt, logic vw, logic fl, logic ov);
        vec_t v;
        v.run = run; v.clr = clr; v.rec = rec; v.view = view;
        v.tin = tin; v.tout = tout; v.idx = idx; v.cnt = cnt;
        v.vw = vw; v.fl = fl; v.ov = ov;
        return v;
    endfunction

    task automatic check(string name, int n, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step%0d: got %0h, want %0h", name, n, act, exp);
        end
    endtask

    task automatic check_all(int n, logic [23:0] t, int idx, int cnt,
                             logic vw, logic fl, logic ov);
        check("time",     n, 32'({bus.min_o, bus.sec_o, bus.ms_10_o}), 32'(t));
        check("lap_idx",  n, 32'(bus.lap_idx), 32'(idx));
        check("lap_cnt",  n, 32'(bus.lap_cnt), 32'(cnt));
        check("viewing",  n, 32'(bus.viewing), 32'(vw));
        check("full",     n, 32'(bus.full), 32'(fl));
        check("overflow", n, 32'(bus.overflow), 32'(ov));
    endtask

    task automatic drive(logic run, logic clr, logic rec, logic view, logic [23:0] t);
        bus.run_en     = run;
        bus.clear      = clr;
        bus.rec_pulse  = rec;
        bus.view_pulse = view;
        {bus.min_i, bus.sec_i, bus.ms_10_i} = t;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        //       run clr rec view  tin         tout        idx cnt vw fl ov
        vt.push_back(mk(1, 0, 0, 0, 24'h010203, 24'h010203, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 24'h000050, 24'h000050, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 0, 1, 24'h000100, 24'h000100, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 1, 0, 24'h000510, 24'h000510, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 0, 1, 0, 24'h000920, 24'h000920, 0, 2, 0, 0, 0));
        vt.push_back(mk(1, 0, 1, 0, 24'h010030, 24'h010030, 0, 3, 0, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 24'h020000, 24'h020000, 0, 3, 0, 0, 0));
        vt.push_back(mk(1, 0, 0, 1, 24'h030000, 24'h000510, 0, 3, 1, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 24'h040000, 24'h000510, 0, 3, 1, 0, 0));
        vt.push_back(mk(1, 0, 0, 1, 24'h040100, 24'h000920, 1, 3, 1, 0, 0));
        vt.push_back(mk(1, 0, 0, 1, 24'h040200, 24'h010030, 2, 3, 1, 0, 0));
        vt.push_back(mk(1, 0, 0, 1, 24'h050000, 24'h050000, 0, 3, 0, 0, 0));
        vt.push_back(mk(1, 0, 1, 0, 24'h060000, 24'h060000, 0, 4, 0, 1, 0));
        vt.push_back(mk(1, 0, 1, 0, 24'h070000, 24'h070000, 0, 4, 0, 1, 1));
        vt.push_back(mk(1, 0, 0, 1, 24'h080000, 24'h000510, 0, 4, 1, 1, 1));
        vt.push_back(mk(1, 0, 0, 1, 24'h080100, 24'h000920, 1, 4, 1, 1, 1));
        vt.push_back(mk(1, 0, 0, 1, 24'h080200, 24'h010030, 2, 4, 1, 1, 1));
        vt.push_back(mk(1, 0, 0, 1, 24'h080300, 24'h060000, 3, 4, 1, 1, 1));
        vt.push_back(mk(1, 0, 0, 1, 24'h090000, 24'h090000, 0, 4, 0, 1, 1));
        vt.push_back(mk(1, 1, 0, 0, 24'h0a0000, 24'h0a0000, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 1, 0, 24'h001000, 24'h001000, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 0, 0, 1, 24'h001100, 24'h001000, 0, 1, 1, 0, 0));
        vt.push_back(mk(1, 0, 1, 1, 24'h001200, 24'h001200, 0, 2, 0, 0, 0));
        vt.push_back(mk(1, 0, 0, 1, 24'h001250, 24'h001000, 0, 2, 1, 0, 0));
        vt.push_back(mk(1, 1, 1, 1, 24'h001300, 24'h001300, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 0, 1, 24'h001400, 24'h001400, 0, 0, 0, 0, 0));

        drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
        rst = 1'b1;
        #2 rst = 1'b0;
        #1 check_all(-1, 24'h0, 0, 0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            drive(vt[i].run, vt[i].clr, vt[i].rec, vt[i].view, vt[i].tin);
            @(posedge clk);
            #1 check_all(i, vt[i].tout, vt[i].idx, vt[i].cnt, vt[i].vw, vt[i].fl, vt[i].ov);
        end

        // Capture one lap, enter VIEW, then pull reset low between edges.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 24'h112233);
        @(posedge clk);
        #1 check_all(100, 24'h112233, 0, 1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 24'h445566);
        @(posedge clk);
        #1 check_all(101, 24'h112233, 0, 1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 24'h778899);
        #1 rst = 1'b0;
        #1 check_all(102, 24'h0, 0, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 check_all(103, 24'h0, 0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h0a0b0c);
        @(posedge clk);
        #1 check_all(104, 24'h0a0b0c, 0, 0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
